// File: rtl/max_pool_ctrl.sv
// max_pool_ctrl: sequencer for the 32-lane max reduction unit.
// Groups beats of BANK-lane vectors into pooling windows. It feeds the external max unit
// (din is registered here, repetition/previous_data are issue-time). It also collects one
// signed max per window into a 2-entry fall-through output FIFO.
module max_pool_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int BANK       = 32,
   parameter int BEAT_W     = 8,
   parameter int WIN_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [BEAT_W-1:0]          cfg_beats,
   input  logic [WIN_W-1:0]           cfg_windows,
   output logic                       busy,
   output logic                       done,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_WIDTH*BANK-1:0] s_data,
   output logic [DATA_WIDTH*BANK-1:0] mx_din,
   output logic [1:0]                 mx_repetition,
   output logic [DATA_WIDTH-1:0]      mx_previous_data,
   input  logic [DATA_WIDTH-1:0]      mx_dout,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_WIDTH-1:0]      m_data
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [BEAT_W-1:0]     beats_q, beat_cnt;
   logic [WIN_W-1:0]      wins_q, win_cnt;
   logic                  vld_q, last_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            fifo_cnt;

   logic issue, last_beat, last_win, push, pop;

   assign issue     = s_valid && s_ready;
   assign last_beat = (beat_cnt == beats_q - BEAT_W'(1));
   assign last_win  = (win_cnt == wins_q - WIN_W'(1));
   assign push      = vld_q && last_q;
   assign pop       = m_valid && m_ready;

   // Only accept a beat if the FIFO can still hold every result already in flight.
   assign s_ready = (state_q == RUN) && ((fifo_cnt + {1'b0, push}) < 2'd2);
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign m_valid = (fifo_cnt != 2'd0);
   assign m_data  = fifo_mem[rd_ptr];

   // Issue-time controls for the max unit; previous beat still in stage 2 is bypassed.
   always_comb begin
      mx_repetition    = 2'b00;
      mx_previous_data = acc_q;
      if (issue) begin
         if (beat_cnt == '0)               mx_repetition = 2'b00;
         else if (beat_cnt >= BEAT_W'(3))  mx_repetition = 2'b11;
         else                              mx_repetition = beat_cnt[1:0];
         if (vld_q) mx_previous_data = mx_dout;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (cfg_windows == '0) ? DONE : RUN;
         RUN:     if (issue && last_beat && last_win) state_d = DRAIN;
         DRAIN:   if (!vld_q && fifo_cnt == 2'd0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Latch job config on accepted start; step beat/window counters on every issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats_q  <= '0;
         wins_q   <= '0;
         beat_cnt <= '0;
         win_cnt  <= '0;
      end else if (state_q == IDLE && start) begin
         beats_q  <= (cfg_beats == '0) ? BEAT_W'(1) : cfg_beats;
         wins_q   <= cfg_windows;
         beat_cnt <= '0;
         win_cnt  <= '0;
      end else if (issue) begin
         if (last_beat) begin
            beat_cnt <= '0;
            win_cnt  <= last_win ? '0 : win_cnt + WIN_W'(1);
         end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
         end
      end
   end

   // Stage 2: register the vector for the max unit and fold its result into acc_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mx_din <= '0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         acc_q  <= '0;
      end else begin
         vld_q <= issue;
         if (issue) begin
            mx_din <= s_data;
            last_q <= last_beat;
         end
         if (vld_q) acc_q <= mx_dout;
      end
   end

   // Two-entry fall-through result FIFO; simultaneous push and pop keep the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= mx_dout;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule
